// File: rtl/mips_pkg.sv
// Shared MIPS definitions: SPECIAL opcode, multiply/divide and HI/LO move
// funct codes, and the encoding of the multiply/divide unit's FSM states.
package mips_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdStateT;

endpackage

// File: rtl/ex_muldiv_core.sv
// Iterative multiply/divide datapath: one radix-2 step per clock.
// Ports:
//   clock, reset     rising-edge clock, async active-high reset
//   start            latch operands and clear the accumulator
//   step             run one shift-add (multiply) or restoring (divide) step
//   isDiv, isSigned  operation kind, sampled with start
//   a, b             dividend/multiplicand and divisor/multiplier
//   resHi, resLo     sign-corrected result as it will stand after this step
import mips_pkg::*;

module ex_muldiv_core (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        step,
  input  logic        isDiv,
  input  logic        isSigned,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] resHi,
  output logic [31:0] resLo
);

  logic [31:0] opnd, accHi, accLo, rawA;
  logic        opDiv, signA, signB, divZero;
  logic [31:0] magA, magB;
  logic [32:0] sum, shifted;
  logic [31:0] diff, nextHi, nextLo, quo, rem;
  logic [63:0] prod, prodFix;

  assign magA = (isSigned && a[31]) ? (~a + 32'd1) : a;
  assign magB = (isSigned && b[31]) ? (~b + 32'd1) : b;

  // Multiply: {accHi, accLo} is {partial sum, remaining multiplier bits}.
  // Divide:   accHi is the partial remainder, accLo shifts dividend out
  //           at the top and quotient bits in at the bottom.
  assign sum     = {1'b0, accHi} + {1'b0, (accLo[0] ? opnd : 32'd0)};
  assign shifted = {accHi, accLo[31]};
  assign diff    = shifted[31:0] - opnd;

  always_comb begin
    nextHi = accHi;
    nextLo = accLo;
    if (opDiv) begin
      if (shifted >= {1'b0, opnd}) begin
        nextHi = diff;
        nextLo = {accLo[30:0], 1'b1};
      end else begin
        nextHi = shifted[31:0];
        nextLo = {accLo[30:0], 1'b0};
      end
    end else begin
      nextHi = sum[32:1];
      nextLo = {sum[0], accLo[31:1]};
    end
  end

  // signA/signB are only set for signed ops, so unsigned ops never negate.
  assign prod    = {nextHi, nextLo};
  assign prodFix = (signA ^ signB) ? (~prod + 64'd1) : prod;
  assign quo     = (signA ^ signB) ? (~nextLo + 32'd1) : nextLo;
  assign rem     = signA ? (~nextHi + 32'd1) : nextHi;

  always_comb begin
    resHi = prodFix[63:32];
    resLo = prodFix[31:0];
    if (divZero) begin
      resHi = rawA;
      resLo = 32'hFFFF_FFFF;
    end else if (opDiv) begin
      resHi = rem;
      resLo = quo;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      opnd    <= '0;
      accHi   <= '0;
      accLo   <= '0;
      rawA    <= '0;
      opDiv   <= 1'b0;
      signA   <= 1'b0;
      signB   <= 1'b0;
      divZero <= 1'b0;
    end else if (start) begin
      opDiv   <= isDiv;
      signA   <= isSigned & a[31];
      signB   <= isSigned & b[31];
      divZero <= isDiv && (b == 32'd0);
      rawA    <= a;
      opnd    <= isDiv ? magB : magA;
      accHi   <= '0;
      accLo   <= isDiv ? magA : magB;
    end else if (step) begin
      accHi <= nextHi;
      accLo <= nextLo;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit with architectural HI/LO registers.
// Ports:
//   clock, reset   rising-edge clock, async active-high reset
//   iInstr         ID/EX instruction word
//   iA, iB         rs / rt operands
//   ivalid         ID/EX entry is live
//   iFlush         squash the in-flight operation / block this cycle's op
//   oStall         hold the ID/EX register (combinational)
//   oResult        HI or LO for MFHI/MFLO, else 0 (combinational)
//   oHI, oLO       architectural HI/LO
//   oBusy          an iterative operation is running
//
// state | meaning
// IDLE  | accepts MULT/DIV, executes MTHI/MTLO/MFHI/MFLO
// BUSY  | 32 iteration edges; HI/LO written on the edge where count==31
import mips_pkg::*;

module ex_muldiv (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] iInstr,
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  input  logic        ivalid,
  input  logic        iFlush,
  output logic        oStall,
  output logic [31:0] oResult,
  output logic [31:0] oHI,
  output logic [31:0] oLO,
  output logic        oBusy
);

  mdStateT     state;
  logic [4:0]  count;
  logic [31:0] hiReg, loReg, coreHi, coreLo;
  logic [5:0]  funct;
  logic        isSpecial, isMulOp, isDivOp, isSignedOp;
  logic        isMfhi, isMflo, isMthi, isMtlo, isAny, accept;
  logic        unusedInstrBits;

  assign unusedInstrBits = ^iInstr[25:6];

  assign funct      = iInstr[5:0];
  assign isSpecial  = ivalid && (iInstr[31:26] == OP_SPECIAL);
  assign isMulOp    = isSpecial && ((funct == FN_MULT) || (funct == FN_MULTU));
  assign isDivOp    = isSpecial && ((funct == FN_DIV) || (funct == FN_DIVU));
  assign isSignedOp = isSpecial && ((funct == FN_MULT) || (funct == FN_DIV));
  assign isMfhi     = isSpecial && (funct == FN_MFHI);
  assign isMflo     = isSpecial && (funct == FN_MFLO);
  assign isMthi     = isSpecial && (funct == FN_MTHI);
  assign isMtlo     = isSpecial && (funct == FN_MTLO);
  assign isAny      = isMulOp | isDivOp | isMfhi | isMflo | isMthi | isMtlo;

  assign accept  = (state == IDLE) && !iFlush && (isMulOp || isDivOp);
  assign oStall  = isAny && (state == BUSY) && !iFlush;
  assign oBusy   = (state == BUSY);
  assign oHI     = hiReg;
  assign oLO     = loReg;
  assign oResult = (state != IDLE) ? 32'd0 :
                   isMfhi          ? hiReg :
                   isMflo          ? loReg : 32'd0;

  ex_muldiv_core uCore (
    .clock    (clock),
    .reset    (reset),
    .start    (accept),
    .step     (state == BUSY),
    .isDiv    (isDivOp),
    .isSigned (isSignedOp),
    .a        (iA),
    .b        (iB),
    .resHi    (coreHi),
    .resLo    (coreLo)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      hiReg <= '0;
      loReg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!iFlush) begin
            if (accept) begin
              state <= BUSY;
              count <= '0;
            end
            if (isMthi) hiReg <= iA;
            if (isMtlo) loReg <= iA;
          end
        end
        BUSY: begin
          if (iFlush) begin
            state <= IDLE;
          end else if (count == 5'd31) begin
            hiReg <= coreHi;
            loReg <= coreLo;
            state <= IDLE;
          end else begin
            count <= count + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
import mips_pkg::*;

module tb_ex_muldiv;

  logic        clock, reset, ivalid, iFlush;
  logic [31:0] iInstr, iA, iB;
  logic        oStall, oBusy;
  logic [31:0] oResult, oHI, oLO;

  int nVec = 0;
  int nErr = 0;

  ex_muldiv dut (
    .clock   (clock),
    .reset   (reset),
    .iInstr  (iInstr),
    .iA      (iA),
    .iB      (iB),
    .ivalid  (ivalid),
    .iFlush  (iFlush),
    .oStall  (oStall),
    .oResult (oResult),
    .oHI     (oHI),
    .oLO     (oLO),
    .oBusy   (oBusy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Results from plain integer arithmetic; timing as "edge number at which
  // HI/LO change", i.e. 32 edges after the accept edge.
  logic [31:0] mHi = 0, mLo = 0, pendHi = 0, pendLo = 0;
  int edgeNo = 0, doneEdge = 0;

  function automatic logic [63:0] refOp(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    longint sp;
    logic [63:0] res;
    sa = a; sb = b;
    res = '0;
    case (fn)
      FN_MULT:  begin sp = longint'(sa) * longint'(sb); res = sp; end
      FN_MULTU: res = {32'd0, a} * {32'd0, b};
      FN_DIV: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'd0, 32'h8000_0000};
        else begin q = sa / sb; r = sa % sb; res = {r, q}; end
      end
      FN_DIVU: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  function automatic bit isMd(input logic [5:0] fn);
    return fn == FN_MULT || fn == FN_MULTU || fn == FN_DIV || fn == FN_DIVU;
  endfunction

  function automatic bit isHiLoFn(input logic [5:0] fn);
    return isMd(fn) || fn == FN_MFHI || fn == FN_MFLO || fn == FN_MTHI || fn == FN_MTLO;
  endfunction

  always @(posedge clock or posedge reset) begin
    bit wasBusy, dec;
    logic [63:0] r;
    if (reset) begin
      mHi = 0; mLo = 0; doneEdge = edgeNo;
    end else begin
      wasBusy = edgeNo < doneEdge;
      dec = ivalid && iInstr[31:26] == OP_SPECIAL;
      edgeNo++;
      if (wasBusy) begin
        if (iFlush) doneEdge = edgeNo;
        else if (edgeNo == doneEdge) begin mHi = pendHi; mLo = pendLo; end
      end else if (dec && !iFlush) begin
        if (isMd(iInstr[5:0])) begin
          r = refOp(iInstr[5:0], iA, iB);
          pendHi = r[63:32]; pendLo = r[31:0];
          doneEdge = edgeNo + 32;
        end else if (iInstr[5:0] == FN_MTHI) mHi = iA;
        else if (iInstr[5:0] == FN_MTLO) mLo = iA;
      end
    end
  end

  always @(negedge clock) begin
    bit busy, dec;
    logic [31:0] expRes;
    busy = !reset && (edgeNo < doneEdge);
    dec = ivalid && iInstr[31:26] == OP_SPECIAL;
    expRes = 0;
    if (!busy && dec && iInstr[5:0] == FN_MFHI) expRes = mHi;
    if (!busy && dec && iInstr[5:0] == FN_MFLO) expRes = mLo;
    check("oBusy", {31'd0, oBusy}, {31'd0, busy});
    check("oStall", {31'd0, oStall}, {31'd0, dec && isHiLoFn(iInstr[5:0]) && busy && !iFlush});
    check("oResult", oResult, expRes);
    check("oHI", oHI, mHi);
    check("oLO", oLO, mLo);
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] rtype(input logic [5:0] fn);
    return {OP_SPECIAL, 20'd0, fn};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic setIn(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                       input logic v, input logic f);
    iInstr = ins; iA = a; iB = b; ivalid = v; iFlush = f;
  endtask

  // Issue one op followed by bubbles; returns number of cycles oBusy was high.
  task automatic runOp(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b, output int n);
    setIn(rtype(fn), a, b, 1'b1, 1'b0);
    tick();
    setIn(32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    n = 0;
    while (oBusy && n < 100) begin n++; tick(); end
  endtask

  int n;

  initial begin
    setIn(32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("rst_hi", oHI, 32'd0);
    check("rst_busy", {31'd0, oBusy}, 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    runOp(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    check("multu_cycles", n, 32);
    check("multu_hi", oHI, 32'hFFFF_FFFE);
    check("multu_lo", oLO, 32'h0000_0001);

    runOp(FN_MULT, 32'hFFFF_FFFD, 32'd7, n);
    check("mult_hi", oHI, 32'hFFFF_FFFF);
    check("mult_lo", oLO, 32'hFFFF_FFEB);

    runOp(FN_DIV, 32'hFFFF_FFF9, 32'd2, n);
    check("div_lo", oLO, 32'hFFFF_FFFD);
    check("div_hi", oHI, 32'hFFFF_FFFF);

    runOp(FN_DIVU, 32'd100, 32'd0, n);
    check("divu0_lo", oLO, 32'hFFFF_FFFF);
    check("divu0_hi", oHI, 32'd100);

    runOp(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
    check("divovf_lo", oLO, 32'h8000_0000);
    check("divovf_hi", oHI, 32'd0);

    runOp(FN_DIV, 32'hFFFF_FFF9, 32'd0, n);
    check("div0s_lo", oLO, 32'hFFFF_FFFF);
    check("div0s_hi", oHI, 32'hFFFF_FFF9);

    runOp(FN_MULT, 32'h7FFF_FFFF, 32'h8000_0000, n);
    runOp(FN_DIV, 32'd100, 32'hFFFF_FFF9, n);
    runOp(FN_DIVU, 32'hDEAD_BEEF, 32'd12345, n);

    // DIVU 50/7 then MFLO waiting behind it
    setIn(rtype(FN_DIVU), 32'd50, 32'd7, 1'b1, 1'b0);
    tick();
    setIn(rtype(FN_MFLO), 32'd0, 32'd0, 1'b1, 1'b0);
    n = 0;
    while (oStall && n < 100) begin n++; tick(); end
    check("mflo_stall", n, 32);
    check("mflo_result", oResult, 32'd7);
    tick();

    // MULTU waiting behind DIVU: accepted one cycle after completion
    setIn(rtype(FN_DIVU), 32'd50, 32'd7, 1'b1, 1'b0);
    tick();
    setIn(rtype(FN_MULTU), 32'd3, 32'd4, 1'b1, 1'b0);
    n = 0;
    while (oStall && n < 100) begin n++; tick(); end
    check("b2b_stall", n, 32);
    check("b2b_lo_div", oLO, 32'd7);
    check("b2b_hi_div", oHI, 32'd1);
    tick();
    setIn(32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    n = 0;
    while (oBusy && n < 100) begin n++; tick(); end
    check("b2b_lo_mul", oLO, 32'd12);

    // unrelated ADD during BUSY never stalls
    setIn(rtype(FN_MULT), 32'd9, 32'd9, 1'b1, 1'b0);
    tick();
    setIn(rtype(6'h20), 32'd1, 32'd2, 1'b1, 1'b0);
    tick();
    check("add_nostall", {31'd0, oStall}, 32'd0);
    n = 0;
    while (oBusy && n < 100) begin n++; tick(); end
    check("add_mult_lo", oLO, 32'd81);

    // MTHI/MTLO then flushed MULT
    setIn(rtype(FN_MTHI), 32'h1234, 32'd0, 1'b1, 1'b0); tick();
    setIn(rtype(FN_MTLO), 32'h5678, 32'd0, 1'b1, 1'b0); tick();
    setIn(rtype(FN_MFHI), 32'd0, 32'd0, 1'b1, 1'b0); #1;
    check("mfhi_result", oResult, 32'h1234);
    tick();
    setIn(rtype(FN_MULT), 32'd5, 32'd6, 1'b1, 1'b0); tick();
    setIn(32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (9) tick();
    iFlush = 1'b1;
    tick();
    iFlush = 1'b0;
    check("flush_busy", {31'd0, oBusy}, 32'd0);
    check("flush_hi", oHI, 32'h1234);
    check("flush_lo", oLO, 32'h5678);
    repeat (40) tick();
    check("flush_lo_late", oLO, 32'h5678);

    // flush in IDLE blocks MTHI and acceptance
    setIn(rtype(FN_MTHI), 32'hAAAA, 32'd0, 1'b1, 1'b1); tick();
    setIn(rtype(FN_MULT), 32'd2, 32'd2, 1'b1, 1'b1); tick();
    check("idleflush_hi", oHI, 32'h1234);
    check("idleflush_busy", {31'd0, oBusy}, 32'd0);
    setIn(32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();

    // async reset at BUSY cycle 5
    setIn(rtype(FN_MULT), 32'd5, 32'd6, 1'b1, 1'b0); tick();
    setIn(32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (4) tick();
    #2 reset = 1'b1;
    #1;
    check("arst_busy", {31'd0, oBusy}, 32'd0);
    check("arst_hi", oHI, 32'd0);
    check("arst_lo", oLO, 32'd0);
    #1 reset = 1'b0;
    repeat (40) tick();
    check("arst_lo_late", oLO, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high; ports are named clock and reset.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 iInstr  input  32  instruction held in the ID/EX register.
REQ-005 iA, iB  input  32 each  rs and rt operands from the ID/EX register.
REQ-006 ivalid  input  1  the ID/EX entry is a live instruction.
REQ-007 iFlush  input  1  aborts the in-flight operation (branch/exception squash).
REQ-008 oStall  output  1  combinational; when high, the ID/EX register enable SHALL be driven low.
REQ-009 oResult  output  32  combinational HI or LO value for MFHI/MFLO; 0 otherwise.
REQ-010 oHI, oLO  output  32 each  architectural HI/LO registers.
REQ-011 oBusy  output  1  high while state is BUSY.

Function
REQ-012 Decoding SHALL apply only when opcode iInstr[31:26]==0 and ivalid==1; funct iInstr[5:0] SHALL select MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13.
REQ-013 The FSM SHALL have exactly two states, IDLE and BUSY, plus a 5-bit iteration counter.
REQ-014 In IDLE, with no iFlush, a MULT/MULTU/DIV/DIVU SHALL be accepted at the clock edge: operands are latched, counter=0, state->BUSY.
REQ-015 In BUSY, one radix-2 step SHALL execute per edge (shift-add for multiply, restoring for divide); on the edge where counter==31, HI/LO are written and state->IDLE, so HI/LO update 32 edges after the accept edge.
REQ-016 Signed ops SHALL operate on magnitudes, then negate: the product if operand signs differ, the quotient if signs differ, the remainder if the dividend is negative.
REQ-017 Multiply SHALL write HI=product[63:32] and LO=product[31:0]; divide SHALL write LO=quotient and HI=remainder.
REQ-018 Divide by zero SHALL write LO=0xFFFFFFFF and HI=iA as latched, for both DIV and DIVU.
REQ-019 DIV 0x80000000 / 0xFFFFFFFF SHALL write LO=0x80000000 and HI=0.
REQ-020 oStall SHALL be 1 exactly when ivalid, the decoded funct is any of the eight codes, state==BUSY, and iFlush==0; unrelated instructions SHALL never stall.
REQ-021 MTHI/MTLO in IDLE SHALL write iA to HI/LO at the edge; they SHALL take effect for the next instruction.
REQ-022 MFHI/MFLO in IDLE SHALL drive oResult=HI/LO in the same cycle; while stalled, oResult SHALL be 0.
REQ-023 iFlush in BUSY SHALL return the FSM to IDLE at the next edge with HI/LO unchanged.
REQ-024 iFlush in IDLE SHALL block acceptance and MTHI/MTLO writes in that cycle.
REQ-025 When the final BUSY edge coincides with a waiting op, that op SHALL see IDLE in the following cycle and be accepted then; there SHALL be no back-to-back acceptance in the completion cycle.

Reset
REQ-026 Reset asserted SHALL immediately force state=IDLE, counter=0, HI=LO=0, and all operand/accumulator registers=0; oStall=0, oBusy=0, oResult=0 while reset is held.
REQ-027 Reset mid-operation SHALL discard the operation with no HI/LO write.

Structure
REQ-028 The funct codes, opcode SPECIAL=0, and the state encoding SHALL reside in the shared package mips_pkg.
REQ-029 The iteration datapath SHALL be one sub-module, ex_muldiv_core (operand latch, accumulator, step logic, sign fix-up); the FSM, decode, HI/LO, and stall logic SHALL remain in ex_muldiv.

Verification
REQ-030 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> 32 edges later HI=0xFFFFFFFE, LO=0x00000001; oBusy high for exactly 32 cycles.
REQ-031 MULT -3 x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-032 DIVU 100 / 0 -> LO=0xFFFFFFFF, HI=100; DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
REQ-033 DIVU 50/7 followed immediately by MFLO -> oStall=1 for 32 cycles, then oResult=7; an unrelated ADD during BUSY -> oStall=0.
REQ-034 MULT in flight with iFlush at BUSY cycle 10 -> IDLE next edge, HI/LO retain 0x1234/0x5678 set earlier by MTHI/MTLO; async reset at BUSY cycle 5 -> IDLE, HI=LO=0 with no clock edge needed.
